// File: rtl/fpu_int2float_seq.sv
// Multi-cycle int32/uint32 to IEEE-754 binary32 converter (FCVT.S.W / FCVT.S.WU).
// Normalizes with an iterative leading-zero shift, then rounds by RISC-V rm.
module fpu_int2float_seq #(
    parameter int unsigned LZ_STEP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] int_in,
    input  logic        is_unsigned,
    input  logic [2:0]  rm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        inexact
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_ROUND = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam logic [7:0] EXP_INIT = 8'd158;

    logic [1:0]  state_q,   state_d;
    logic        sign_q,    sign_d;
    logic [2:0]  rm_q,      rm_d;
    logic [31:0] mag_q,     mag_d;
    logic [7:0]  exp_q,     exp_d;
    logic [31:0] result_q,  result_d;
    logic        inexact_q, inexact_d;

    logic        rnd_lsb;
    logic        rnd_g;
    logic        rnd_s;
    logic        rnd_inc;
    logic [23:0] frac_sum;

    // Round-increment decision and mantissa increment from the normalized magnitude
    always_comb begin
        rnd_lsb = mag_q[8];
        rnd_g   = mag_q[7];
        rnd_s   = |mag_q[6:0];
        rnd_inc = 1'b0;
        case (rm_q)
            RM_RNE:  rnd_inc = rnd_g & (rnd_s | rnd_lsb);
            RM_RTZ:  rnd_inc = 1'b0;
            RM_RDN:  rnd_inc = sign_q & (rnd_g | rnd_s);
            RM_RUP:  rnd_inc = ~sign_q & (rnd_g | rnd_s);
            RM_RMM:  rnd_inc = rnd_g;
            default: rnd_inc = rnd_g & (rnd_s | rnd_lsb);
        endcase
        frac_sum = {1'b0, mag_q[30:8]} + 24'(rnd_inc);
    end

    // Next-state and datapath update for the IDLE/NORM/ROUND/DONE sequence
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        rm_d      = rm_q;
        mag_d     = mag_q;
        exp_d     = exp_q;
        result_d  = result_q;
        inexact_d = inexact_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = ~is_unsigned & int_in[31];
                    rm_d   = rm;
                    mag_d  = sign_d ? (~int_in + 32'd1) : int_in;
                    exp_d  = EXP_INIT;
                    if (mag_d == 32'd0) begin
                        result_d  = 32'd0;
                        inexact_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        state_d = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                // Nonzero magnitude guarantees exp stays at or above 127
                if (mag_q[31]) begin
                    state_d = ST_ROUND;
                end else if (mag_q[31 -: LZ_STEP] == '0) begin
                    mag_d = mag_q << LZ_STEP;
                    exp_d = exp_q - 8'(LZ_STEP);
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            ST_ROUND: begin
                // Carry out of the fraction bumps the exponent; at most 159, so no overflow
                if (frac_sum[23]) begin
                    exp_d = exp_q + 8'd1;
                end
                result_d  = {sign_q, exp_d, frac_sum[22:0]};
                inexact_d = rnd_g | rnd_s;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            rm_q      <= RM_RNE;
            mag_q     <= 32'd0;
            exp_q     <= 8'd0;
            result_q  <= 32'd0;
            inexact_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            rm_q      <= rm_d;
            mag_q     <= mag_d;
            exp_q     <= exp_d;
            result_q  <= result_d;
            inexact_q <= inexact_d;
        end
    end

    // Handshake flags decode directly from the state register
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_fpu_int2float_seq.sv
// Directed bench for fpu_int2float_seq; a second instance runs with LZ_STEP=4.
module tb_fpu_int2float_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] int_in;
    logic        is_unsigned;
    logic [2:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        inexact;

    logic        in_ready4;
    logic        out_valid4;
    logic [31:0] result4;
    logic        inexact4;

    int checks;
    int failures;

    fpu_int2float_seq #(.LZ_STEP(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .int_in      (int_in),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .inexact     (inexact)
    );

    fpu_int2float_seq #(.LZ_STEP(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready4),
        .int_in      (int_in),
        .is_unsigned (is_unsigned),
        .rm          (rm),
        .out_valid   (out_valid4),
        .out_ready   (out_ready),
        .result      (result4),
        .inexact     (inexact4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand, measure edges after the accept edge until out_valid, then drain
    task automatic convert(input string tag, input logic [31:0] val, input logic uns,
                           input logic [2:0] mode, input logic [31:0] exp_res,
                           input logic exp_nx, input int exp_lat);
        int lat;
        check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        int_in      = val;
        is_unsigned = uns;
        rm          = mode;
        tick();
        in_valid    = 1'b0;
        int_in      = $urandom;
        is_unsigned = ~uns;
        rm          = 3'b011;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, " lat"}, 32'(lat), 32'(exp_lat));
        check({tag, " res"}, result, exp_res);
        check({tag, " nx"}, 32'(inexact), 32'(exp_nx));
        check({tag, " res4"}, result4, exp_res);
        check({tag, " nx4"}, 32'(inexact4), 32'(exp_nx));
        check({tag, " ov4"}, 32'(out_valid4), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " ov_drop"}, 32'(out_valid), 32'd0);
        check({tag, " rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        int_in      = 32'd0;
        is_unsigned = 1'b0;
        rm          = 3'b000;
        out_ready   = 1'b0;
        tick();
        tick();
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result",    result,         32'd0);
        check("rst inexact",   32'(inexact),   32'd0);
        rst = 1'b0;
        tick();

        convert("neg6_rne",     32'hFFFF_FFFA, 1'b0, 3'b000, 32'hC0C0_0000, 1'b0, 31);
        convert("max_rne",      32'h7FFF_FFFF, 1'b0, 3'b000, 32'h4F00_0000, 1'b1, 3);
        convert("max_rtz",      32'h7FFF_FFFF, 1'b0, 3'b001, 32'h4EFF_FFFF, 1'b1, 3);
        convert("min_s",        32'h8000_0000, 1'b0, 3'b000, 32'hCF00_0000, 1'b0, 2);
        convert("umax_rne",     32'hFFFF_FFFF, 1'b1, 3'b000, 32'h4F80_0000, 1'b1, 2);
        convert("umax_rdn",     32'hFFFF_FFFF, 1'b1, 3'b010, 32'h4F7F_FFFF, 1'b1, 2);
        convert("u80",          32'h8000_0000, 1'b1, 3'b000, 32'h4F00_0000, 1'b0, 2);
        convert("tie_rne",      32'h0100_0001, 1'b0, 3'b000, 32'h4B80_0000, 1'b1, 9);
        convert("tie_rup",      32'h0100_0001, 1'b0, 3'b011, 32'h4B80_0001, 1'b1, 9);
        convert("tie_rmm",      32'h0100_0001, 1'b0, 3'b100, 32'h4B80_0001, 1'b1, 9);
        convert("tie_rm7",      32'h0100_0001, 1'b0, 3'b111, 32'h4B80_0000, 1'b1, 9);
        convert("zero",         32'h0000_0000, 1'b0, 3'b000, 32'h0000_0000, 1'b0, 0);
        convert("one",          32'h0000_0001, 1'b0, 3'b000, 32'h3F80_0000, 1'b0, 33);

        // Backpressure: result held while the consumer stalls; new operands ignored
        in_valid    = 1'b1;
        int_in      = 32'h7FFF_FFFF;
        is_unsigned = 1'b0;
        rm          = 3'b000;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("bp lat", 32'(lat), 32'd3);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            int_in   = 32'h0000_0003;
            tick();
            check("bp result",    result,         32'h4F00_0000);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready",  32'(in_ready),  32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp ov_drop",  32'(out_valid), 32'd0);
        check("bp rdy_back", 32'(in_ready),  32'd1);
        check("bp result_keep", result,      32'h4F00_0000);

        // Reset in the middle of normalization discards the operation
        in_valid = 1'b1;
        int_in   = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst in_ready",  32'(in_ready),  32'd1);
        check("mrst out_valid", 32'(out_valid), 32'd0);
        check("mrst result",    result,         32'd0);
        check("mrst inexact",   32'(inexact),   32'd0);
        convert("three", 32'h0000_0003, 1'b0, 3'b000, 32'h4040_0000, 1'b0, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
